// File: rtl/mult_lane_pkg.sv
// mult_lane_pkg: op codes, op type and accumulator width rule shared by the lane array
package mult_lane_pkg;
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;
  localparam logic [1:0] OP_LDMAC = 2'b11;
  typedef logic [1:0] op_t;
  function automatic int acc_w(input int dw, input int g);
    return 2 * dw + g;
  endfunction
endpackage

// File: rtl/mult_lane.sv
// mult_lane: one lane's product pipeline and accumulator.
// MULT_LANE_SAT_EN makes MAC saturate and drives a sticky overflow flag.
module mult_lane
  import mult_lane_pkg::*;
#(
  parameter int DWIDTH      = 36,
  parameter int PIPE_STAGES = 3,
  parameter int GUARD_BITS  = 8,
  parameter int ACC_W       = acc_w(DWIDTH, GUARD_BITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              fire,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [1:0]        op,
  output logic [ACC_W-1:0]  data,
  output logic              ovf
);
  localparam int L = PIPE_STAGES - 1;
  logic [DWIDTH-1:0] a0, b0;
  op_t op0;
  logic [2*DWIDTH-1:0] prod [1:L];
  logic [DWIDTH:0] sum [1:L];
  op_t opq [1:L];
  logic [ACC_W-1:0] acc, pz, sz, mac, res;
  // stages 1..L only delay the product so synthesis can retime the multiplier
  always_ff @(posedge clk) begin
    if (en) begin
      a0 <= a;
      b0 <= b;
      op0 <= op;
      prod[1] <= {{DWIDTH{1'b0}}, a0} * {{DWIDTH{1'b0}}, b0};
      sum[1] <= {1'b0, a0} + {1'b0, b0};
      opq[1] <= op0;
      for (int j = 2; j <= L; j++) begin
        prod[j] <= prod[j-1];
        sum[j] <= sum[j-1];
        opq[j] <= opq[j-1];
      end
    end
  end
  assign pz = {{GUARD_BITS{1'b0}}, prod[L]};
  assign sz = {{(ACC_W-DWIDTH-1){1'b0}}, sum[L]};
`ifdef MULT_LANE_SAT_EN
  logic [ACC_W:0] mac_full;
  assign mac_full = {1'b0, acc} + {1'b0, pz};
  assign mac = mac_full[ACC_W] ? '1 : mac_full[ACC_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else if (fire && opq[L] == OP_LDMAC) ovf <= 1'b0;
    else if (fire && opq[L] == OP_MAC && mac_full[ACC_W]) ovf <= 1'b1;
  end
`else
  assign mac = acc + pz;
  assign ovf = 1'b0;
`endif
  assign res = opq[L] == OP_ADD ? sz : opq[L] == OP_MAC ? mac : pz;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      data <= '0;
    end else if (fire) begin
      data <= res;
      if (opq[L] == OP_MAC) acc <= mac;
      else if (opq[L] == OP_LDMAC) acc <= pz;
    end
  end
endmodule

// File: rtl/mult_lane_array.sv
// mult_lane_array: NUM_CH lock-step multiply/accumulate lanes behind one valid/ready handshake.
// Optional saturation via MULT_LANE_SAT_EN.
module mult_lane_array
  import mult_lane_pkg::*;
#(
  parameter int DWIDTH      = 36,
  parameter int NUM_CH      = 3,
  parameter int PIPE_STAGES = 3,
  parameter int GUARD_BITS  = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [1:0]                                  in_op,
  input  logic [NUM_CH*DWIDTH-1:0]                    in_a,
  input  logic [NUM_CH*DWIDTH-1:0]                    in_b,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_CH*(2*DWIDTH+GUARD_BITS)-1:0]     out_data,
  output logic [NUM_CH-1:0]                           out_ovf
);
  localparam int ACC_W = acc_w(DWIDTH, GUARD_BITS);
  logic en, fire;
  logic [PIPE_STAGES-1:0] vld;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign fire = en && vld[PIPE_STAGES-1];
  // bubbles shift through like data so latency stays fixed
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld <= {vld[PIPE_STAGES-2:0], in_valid};
      out_valid <= vld[PIPE_STAGES-1];
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mult_lane #(
      .DWIDTH(DWIDTH),
      .PIPE_STAGES(PIPE_STAGES),
      .GUARD_BITS(GUARD_BITS),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk(clk),
      .reset(reset),
      .en(en),
      .fire(fire),
      .a(in_a[i*DWIDTH +: DWIDTH]),
      .b(in_b[i*DWIDTH +: DWIDTH]),
      .op(in_op),
      .data(out_data[i*ACC_W +: ACC_W]),
      .ovf(out_ovf[i])
    );
  end
endmodule

// File: tb/tb_mult_lane_array.sv
// tb_mult_lane_array: random and directed stimulus against a transaction-level lane model
module tb_mult_lane_array;
  localparam int DW = 36;
  localparam int NC = 3;
  localparam int P  = 3;
  localparam int AW = 2 * DW + 8;
`ifdef MULT_LANE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [NC*AW-1:0] d;
    logic [NC-1:0]    o;
  } ent_t;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_op;
  logic [NC*DW-1:0] in_a, in_b;
  logic [NC*AW-1:0] out_data;
  logic [NC-1:0] out_ovf;
  int errs = 0, checks = 0, ready_mode = 0, stall_left = 0;
  ent_t q[$];
  logic [AW-1:0] acc_m [NC];
  logic ovf_m [NC];
  mult_lane_array #(.DWIDTH(DW), .NUM_CH(NC), .PIPE_STAGES(P), .GUARD_BITS(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NC; i++) begin
      acc_m[i] = '0;
      ovf_m[i] = 1'b0;
    end
  endtask
  task automatic model_accept();
    ent_t e;
    logic [DW-1:0] a, b;
    logic [AW:0] p, s;
    logic [AW-1:0] r;
    for (int i = 0; i < NC; i++) begin
      a = in_a[i*DW +: DW];
      b = in_b[i*DW +: DW];
      p = (AW+1)'(a) * (AW+1)'(b);
      case (in_op)
        2'b00: r = p[AW-1:0];
        2'b01: r = AW'(a) + AW'(b);
        2'b10: begin
          s = {1'b0, acc_m[i]} + p;
          if (SAT && s[AW]) begin
            s = {1'b0, {AW{1'b1}}};
            ovf_m[i] = 1'b1;
          end
          acc_m[i] = s[AW-1:0];
          r = acc_m[i];
        end
        default: begin
          acc_m[i] = p[AW-1:0];
          ovf_m[i] = 1'b0;
          r = acc_m[i];
        end
      endcase
      e.d[i*AW +: AW] = r;
      e.o[i] = ovf_m[i];
    end
    q.push_back(e);
  endtask
  // one clock: decide out_ready, score what the coming edge does, then advance to the next negedge
  task automatic tick(output bit acc);
    out_ready = ready_mode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end
    #1;
    acc = in_valid && in_ready && !reset;
    if (reset) model_reset();
    else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("data", out_data, q[0].d);
          chk("ovf", out_ovf, q[0].o);
          if (out_ready) void'(q.pop_front());
        end
        if (!out_ready) chk("in_ready_stall", in_ready, 0);
      end
      if (acc) model_accept();
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    bit x;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(x);
  endtask
  task automatic send(input logic [1:0] op, input logic [NC*DW-1:0] a, input logic [NC*DW-1:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 64 && !done; i++) tick(done);
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    ready_mode = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
    chk("drain", q.size(), 0);
  endtask
  function automatic logic [NC*DW-1:0] all(input logic [DW-1:0] v);
    return {NC{v}};
  endfunction
  initial begin
    logic [63:0] r;
    logic [NC*DW-1:0] ra, rb;
    reset = 1'b1;
    in_valid = 1'b0;
    in_op = 2'b00;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    send(2'b00, {{(NC-1)*DW{1'b0}}, 36'd3}, {{(NC-1)*DW{1'b0}}, 36'd5});
    chk("lat_k0", out_valid, 0);
    idle(1);
    chk("lat_k1", out_valid, 0);
    idle(1);
    chk("lat_k2", out_valid, 0);
    idle(1);
    chk("lat_k3", out_valid, 1);
    chk("lat_data", out_data[AW-1:0], 15);
    drain();
    send(2'b11, all(2), all(7));
    send(2'b10, all(2), all(7));
    send(2'b10, all(2), all(7));
    send(2'b01, all(10), all(4));
    send(2'b10, all(0), all(0));
    drain();
    chk("acc_after_add", out_data[AW-1:0], 42);
    stall_left = 5;
    for (int k = 1; k <= 6; k++) send(2'b10, all(DW'(k)), all(3));
    drain();
    chk("bp_final", out_data[AW-1:0], 42 + 3 * 21);
    send(2'b00, all(9), all(9));
    send(2'b11, all(4), all(4));
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int k = 0; k < P; k++) begin
      chk("rst_quiet", out_valid, 0);
      idle(1);
    end
    send(2'b10, all(1), all(1));
    drain();
    chk("rst_acc_cleared", out_data[AW-1:0], 1);
    send(2'b11, all({DW{1'b1}}), all({DW{1'b1}}));
    for (int k = 0; k < 260; k++) send(2'b10, all({DW{1'b1}}), all({DW{1'b1}}));
    drain();
    chk("ovf_flag", out_ovf[0], SAT);
    chk("ovf_data", out_data[AW-1:0], acc_m[0]);
    send(2'b11, all(1), all(1));
    drain();
    chk("ovf_clear", out_ovf[0], 0);
    ready_mode = 1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NC; i++) begin
        r = {$urandom, $urandom};
        ra[i*DW +: DW] = $urandom_range(0, 1) != 0 ? r[DW-1:0] : DW'($urandom_range(0, 255));
        r = {$urandom, $urandom};
        rb[i*DW +: DW] = $urandom_range(0, 1) != 0 ? r[DW-1:0] : DW'($urandom_range(0, 255));
      end
      send(2'($urandom_range(0, 3)), ra, rb);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mult_lane_array.md
Name: mult_lane_array

Overview:
- Parametrised successor to the fixed 36-bit single-channel registered multiplier/adder feeding the hard-model columns.
- NUM_CH independent arithmetic lanes run in lock-step behind one valid/ready handshake.
- Each lane has a configurable-depth multiply pipeline and a per-lane accumulator, so ops are MUL, ADD, MAC and load-MAC.
- Sits between the BRAM readout and the hard-model column chains; one lane per column.

Parameters:
- DWIDTH, 36, operand width per lane (unsigned).
- NUM_CH, 3, number of lanes/columns.
- PIPE_STAGES, 3, accept-to-result latency in cycles; legal range 2..8.
- GUARD_BITS, 8, extra accumulator MSBs; ACC_W = 2*DWIDTH + GUARD_BITS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept this cycle.
- in_op  in  2  op code: 00 MUL, 01 ADD, 10 MAC, 11 LDMAC.
- in_a  in  NUM_CH*DWIDTH  lane operands A; lane i at [i*DWIDTH +: DWIDTH].
- in_b  in  NUM_CH*DWIDTH  lane operands B, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_CH*ACC_W  lane results; lane i at [i*ACC_W +: ACC_W].
- out_ovf  out  NUM_CH  per-lane sticky overflow flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ovf=0, all lane accumulators 0, all stage-valid bits 0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: every in-flight transaction is discarded and the accumulators clear. No result from before reset ever appears on the output.
- Global enable: en = !out_valid || out_ready; in_ready = en (combinational). All stages advance only when en=1. A bubble advances like data; bubbles are not collapsed.
- Accept: a transaction is accepted on a rising edge where in_valid && in_ready. The operands and op register into stage 0.
- Latency: a transaction accepted at edge k gives out_valid=1 after edge k+PIPE_STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Multiply: the lane computes a*b in stage 0. Stages 1..PIPE_STAGES-2 are register delay so the tools can retime the product. The op code and a+b travel alongside.
- Final stage, per lane, applied in order:
  - MUL: result = zero-extended a*b; accumulator unchanged.
  - ADD: result = zero-extended a+b (DWIDTH+1 bits); accumulator unchanged.
  - MAC: acc <= acc + a*b; result = the new acc value.
  - LDMAC: acc <= a*b; result = a*b.
- Hold under backpressure: while out_valid && !out_ready, out_data, out_valid and every accumulator hold their values.
- Back-to-back MACs accumulate in acceptance order with no hazards, because the accumulator is only in the final stage.
- Width rules: all arithmetic is unsigned. Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- Simultaneous events: reset has priority over accept and over output handshake in the same cycle.
- Throughput: 1 transaction per cycle when out_ready is held at 1.

Optional Feature:
- Macro: MULT_LANE_SAT_EN.
- Defined:
  - A MAC whose sum exceeds 2^ACC_W-1 clamps the accumulator and the result to all-ones.
  - That lane's out_ovf bit sets and stays set until reset or an LDMAC on that lane.
- Undefined: the accumulator wraps, and out_ovf is tied to 0.

Decomposition:
- Package mult_lane_pkg holds:
  - the op-code localparams OP_MUL, OP_ADD, OP_MAC, OP_LDMAC;
  - the 2-bit op typedef;
  - the ACC_W derivation function.
- Sub-module mult_lane: one lane's datapath (product pipeline and accumulator), with en and the stage-valid shift register shared from the top.
- The top holds the handshake, the valid shift register and a generate loop over NUM_CH.

Test Plan:
- MUL latency: defaults, out_ready=1. Lane0 a=3, b=5, op MUL at edge k -> out_valid=1 after edge k+3; lane0 out_data=15.
- Accumulate: lanes 0..2 all a=2, b=7. Ops LDMAC, MAC, MAC on consecutive cycles -> results 14, 28, 42 on three consecutive valid cycles; then ADD a=10, b=4 -> 14, with acc still 42.
- Backpressure: out_ready=0 for 5 cycles while 6 MACs are offered.
  - in_ready drops once out_valid=1 with out_ready=0.
  - out_data holds.
  - After out_ready=1, all 6 results arrive in order, none lost or duplicated.
- Reset mid-flight: 2 transactions in flight, reset for 1 cycle -> out_valid stays 0 for PIPE_STAGES cycles, acc=0, so the next MAC a=1, b=1 returns 1.
- Overflow: LDMAC a=b=2^36-1, then repeated MAC until the sum exceeds 2^80-1.
  - Without MULT_LANE_SAT_EN: the result wraps and out_ovf=0.
  - With it: the result is all-ones and out_ovf for that lane is 1, cleared by the next LDMAC.
- Lane independence: NUM_CH=3 with different a/b per lane and a random out_ready pattern -> each lane matches a per-lane reference model.
